// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset PC, queue sizing, exception code, queue entry layout.
// The alignment-check option is controlled by the IF_ALIGN_CHECK_EN macro in if_fetch_unit.
package if_fetch_unit_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;
    localparam int unsigned IF_QDEPTH   = 2;
    localparam int unsigned XLEN        = 32;

    // Address-error-on-load/fetch code consumed by downstream exception logic.
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            exc;
    } fq_entry_t;

    localparam int unsigned FQ_ENTRY_W = $bits(fq_entry_t);

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_queue.sv
// if_fetch_queue: QDEPTH-entry instruction FIFO with synchronous flush.
// Each entry holds {instr, pc, exc}; the head is presented straight from storage flops.
module if_fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned QDEPTH = IF_QDEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [FQ_ENTRY_W-1:0]       push_data,
    input  logic                        pop,
    output logic                        head_valid,
    output logic [FQ_ENTRY_W-1:0]       head_data,
    output logic [$clog2(QDEPTH):0]     count
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    fq_entry_t     mem_q [QDEPTH];
    fq_entry_t     mem_d [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q < CW'(QDEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = fq_entry_t'(push_data);
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = FQ_ENTRY_W'(mem_q[rd_ptr_q]);
    assign count      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. Owns the PC, issues word reads to imem,
// buffers responses in if_fetch_queue and hands them to ID via valid/ready.
// Optional feature: define IF_ALIGN_CHECK_EN to trap misaligned PCs (adds id_exc port).
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter int unsigned QDEPTH   = IF_QDEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        id_exc
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    logic [31:0]           pc_q, pc_d;
    logic [31:0]           inflight_pc_q, inflight_pc_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_kill_q, inflight_kill_d;
    logic [CW-1:0]         q_count;
    logic [FQ_ENTRY_W-1:0] head_data;
    logic [FQ_ENTRY_W-1:0] push_data;
    fq_entry_t             head;
    fq_entry_t             push_entry;
    logic                  pop;
    logic                  push;
    logic                  issue_ok;
    logic                  misaligned;
    logic                  resp_push;
    logic                  exc_push;
    logic                  accept;
    logic [OW-1:0]         occupancy;
    logic [31:0]           redirect_target;
`ifdef IF_ALIGN_CHECK_EN
    logic                  halt_q, halt_d;
`endif

    // Issue decision, response capture and queue push selection.
    always_comb begin
        pop       = id_valid && id_ready;
        occupancy = OW'(q_count) + OW'(inflight_q) - OW'(pop);
        issue_ok  = !rst && !redirect && (occupancy < OW'(QDEPTH));
`ifdef IF_ALIGN_CHECK_EN
        issue_ok        = issue_ok && !halt_q;
        misaligned      = (pc_q[1:0] != 2'b00);
        redirect_target = redirect_pc;
`else
        misaligned      = 1'b0;
        redirect_target = word_align(redirect_pc);
`endif
        imem_req  = issue_ok && !misaligned;
        accept    = imem_req && imem_ready;
        resp_push = inflight_q && !inflight_kill_q && !redirect;
        // A trap entry waits for any outstanding response so only one push occurs per cycle.
        exc_push  = issue_ok && misaligned && !inflight_q;
        push      = resp_push || exc_push;
        if (resp_push) begin
            push_entry.instr = imem_rdata;
            push_entry.pc    = inflight_pc_q;
            push_entry.exc   = 1'b0;
        end else begin
            push_entry.instr = '0;
            push_entry.pc    = pc_q;
            push_entry.exc   = 1'b1;
        end
        push_data = FQ_ENTRY_W'(push_entry);
    end

    // Next PC and in-flight tracking; redirect has priority over sequential advance.
    always_comb begin
        pc_d            = pc_q;
        inflight_pc_d   = inflight_pc_q;
        inflight_d      = accept;
        inflight_kill_d = inflight_kill_q;
        if (redirect) begin
            pc_d            = redirect_target;
            inflight_kill_d = inflight_q;
        end else if (accept) begin
            pc_d            = pc_q + 32'd4;
            inflight_pc_d   = pc_q;
            inflight_kill_d = 1'b0;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    // Issue halts after a misaligned-PC trap until the next redirect.
    always_comb begin
        halt_d = halt_q;
        if (redirect) begin
            halt_d = 1'b0;
        end else if (exc_push) begin
            halt_d = 1'b1;
        end
    end
`endif

    // Fetch control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            inflight_pc_q   <= '0;
            inflight_q      <= 1'b0;
            inflight_kill_q <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            halt_q          <= 1'b0;
`endif
        end else begin
            pc_q            <= pc_d;
            inflight_pc_q   <= inflight_pc_d;
            inflight_q      <= inflight_d;
            inflight_kill_q <= inflight_kill_d;
`ifdef IF_ALIGN_CHECK_EN
            halt_q          <= halt_d;
`endif
        end
    end

    if_fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (id_valid),
        .head_data  (head_data),
        .count      (q_count)
    );

    assign head     = fq_entry_t'(head_data);
    assign id_instr = head.instr;
    assign id_pc    = head.pc;
    assign id_pc4   = head.pc + 32'd4;

`ifdef IF_ALIGN_CHECK_EN
    assign imem_addr = pc_q;
    assign id_exc    = head.exc;
`else
    assign imem_addr = word_align(pc_q);
    logic unused_c;
    assign unused_c = ^{head.exc, redirect_pc[1:0]};
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. Honours IF_ALIGN_CHECK_EN when defined.
// imem model returns the request address as the instruction, one cycle after acceptance.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
`ifdef IF_ALIGN_CHECK_EN
    logic        id_exc;
`endif

    int errors = 0;
    int checks = 0;
    logic [32:0] got_r, exp_r;
    logic [96:0] got_h, exp_h;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .id_exc      (id_exc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: echoes the accepted address next cycle, junk otherwise.
    always @(posedge clk) begin
        imem_rdata <= (imem_req && imem_ready) ? imem_addr : 32'hDEAD_BEEF;
    end

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        imem_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        got_r = {imem_req, imem_addr & 32'h0}; exp_r = 33'h0;
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL reset_req got=%h exp=%h", got_r, exp_r); end
        got_h = {id_valid, id_pc, id_instr, 32'h0}; exp_h = 97'h0;
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL reset_head got=%h exp=%h", got_h, exp_h); end
`ifdef IF_ALIGN_CHECK_EN
        checks++; if (id_exc !== 1'b0) begin errors++; $display("FAIL reset_exc got=%b exp=0", id_exc); end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        rst = 1'b0; id_ready = 1'b1; #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h3000};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL stream_req_c1 got=%h exp=%h", got_r, exp_r); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_c1 got=%b exp=0", id_valid); end
        @(negedge clk); #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h3004};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL stream_req_c2 got=%h exp=%h", got_r, exp_r); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_c2 got=%b exp=0", id_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            got_h = {id_valid, id_pc, id_instr, id_pc4};
            exp_h = {1'b1, 32'h3000 + 32'(4*k), 32'h3000 + 32'(4*k), 32'h3004 + 32'(4*k)};
            checks++; if (got_h !== exp_h) begin errors++; $display("FAIL stream_head_%0d got=%h exp=%h", k, got_h, exp_h); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        rst = 1'b0; id_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (c >= 3) begin
                got_r = {imem_req, 32'h0}; exp_r = 33'h0;
                checks++; if (got_r !== exp_r) begin errors++; $display("FAIL stall_req_c%0d got=%h exp=%h", c, got_r, exp_r); end
            end
        end
        got_h = {id_valid, id_pc, id_instr, id_pc4}; exp_h = {1'b1, 32'h3000, 32'h3000, 32'h3004};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL stall_head_full got=%h exp=%h", got_h, exp_h); end
        @(negedge clk); id_ready = 1'b1; #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h3008};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL stall_release_req got=%h exp=%h", got_r, exp_r); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            got_h = {id_valid, id_pc, id_instr, id_pc4};
            exp_h = {1'b1, 32'h3000 + 32'(4*k), 32'h3000 + 32'(4*k), 32'h3004 + 32'(4*k)};
            checks++; if (got_h !== exp_h) begin errors++; $display("FAIL stall_drain_%0d got=%h exp=%h", k, got_h, exp_h); end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        rst = 1'b0; id_ready = 1'b1; #1;
        @(negedge clk); #1;
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h4000; #1;
        got_r = {imem_req, 32'h0}; exp_r = 33'h0;
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL redir_req_off got=%h exp=%h", got_r, exp_r); end
        got_h = {id_valid, id_pc, id_instr, id_pc4}; exp_h = {1'b1, 32'h3000, 32'h3000, 32'h3004};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL redir_pop_head got=%h exp=%h", got_h, exp_h); end
        @(negedge clk); redirect = 1'b0; #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h4000};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL redir_req_new got=%h exp=%h", got_r, exp_r); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_flushed got=%b exp=0", id_valid); end
        @(negedge clk); #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_push got=%b exp=0", id_valid); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            got_h = {id_valid, id_pc, id_instr, id_pc4};
            exp_h = {1'b1, 32'h4000 + 32'(4*k), 32'h4000 + 32'(4*k), 32'h4004 + 32'(4*k)};
            checks++; if (got_h !== exp_h) begin errors++; $display("FAIL redir_head_%0d got=%h exp=%h", k, got_h, exp_h); end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        rst = 1'b0; id_ready = 1'b0; #1;
        repeat (3) @(negedge clk);
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h5000; #1;
        got_h = {id_valid, id_pc, id_instr, 31'h0, imem_req}; exp_h = {1'b1, 32'h3000, 32'h3000, 32'h0};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL full_redir_cycle got=%h exp=%h", got_h, exp_h); end
        @(negedge clk); redirect = 1'b0; #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h5000};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL full_redir_req got=%h exp=%h", got_r, exp_r); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL full_redir_empty got=%b exp=0", id_valid); end
        @(negedge clk); #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL full_redir_nopush got=%b exp=0", id_valid); end
        @(negedge clk); #1;
        got_h = {id_valid, id_pc, id_instr, id_pc4}; exp_h = {1'b1, 32'h5000, 32'h5000, 32'h5004};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL full_redir_head got=%h exp=%h", got_h, exp_h); end
    endtask

    task automatic test_imem_stall();
        do_reset();
        rst = 1'b0; id_ready = 1'b1; #1;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk); imem_ready = 1'b0; #1;
            got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h3004};
            checks++; if (got_r !== exp_r) begin errors++; $display("FAIL imem_hold_c%0d got=%h exp=%h", c, got_r, exp_r); end
        end
        @(negedge clk); imem_ready = 1'b1; #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h3004};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL imem_resume_req got=%h exp=%h", got_r, exp_r); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL imem_resume_valid got=%b exp=0", id_valid); end
        @(negedge clk); #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h3008};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL imem_next_req got=%h exp=%h", got_r, exp_r); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            got_h = {id_valid, id_pc, id_instr, id_pc4};
            exp_h = {1'b1, 32'h3004 + 32'(4*k), 32'h3004 + 32'(4*k), 32'h3008 + 32'(4*k)};
            checks++; if (got_h !== exp_h) begin errors++; $display("FAIL imem_order_%0d got=%h exp=%h", k, got_h, exp_h); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rst = 1'b0; id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        @(negedge clk); redirect = 1'b0; #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'hFFFF_FFFC};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL wrap_req0 got=%h exp=%h", got_r, exp_r); end
        @(negedge clk); #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h0};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL wrap_req1 got=%h exp=%h", got_r, exp_r); end
        @(negedge clk); #1;
        got_h = {id_valid, id_pc, id_instr, id_pc4}; exp_h = {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL wrap_head0 got=%h exp=%h", got_h, exp_h); end
        @(negedge clk); #1;
        got_h = {id_valid, id_pc, id_instr, id_pc4}; exp_h = {1'b1, 32'h0, 32'h0, 32'h4};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL wrap_head1 got=%h exp=%h", got_h, exp_h); end
    endtask

    task automatic test_align();
        do_reset();
        rst = 1'b0; id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h4002; #1;
        @(negedge clk); redirect = 1'b0; #1;
`ifdef IF_ALIGN_CHECK_EN
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL align_noreq got=%b exp=0", imem_req); end
        @(negedge clk); #1;
        got_h = {id_valid, id_pc, id_instr, id_pc4}; exp_h = {1'b1, 32'h4002, 32'h0, 32'h4006};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL align_trap_head got=%h exp=%h", got_h, exp_h); end
        checks++; if ({id_exc, imem_req} !== 2'b10) begin errors++; $display("FAIL align_trap_exc got=%b exp=10", {id_exc, imem_req}); end
        @(negedge clk); #1;
        checks++; if ({id_valid, imem_req} !== 2'b00) begin errors++; $display("FAIL align_halted got=%b exp=00", {id_valid, imem_req}); end
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h4010; #1;
        @(negedge clk); redirect = 1'b0; #1;
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h4010};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL align_restart_req got=%h exp=%h", got_r, exp_r); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        got_h = {id_valid, id_pc, id_instr, id_pc4}; exp_h = {1'b1, 32'h4010, 32'h4010, 32'h4014};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL align_restart_head got=%h exp=%h", got_h, exp_h); end
        checks++; if (id_exc !== 1'b0) begin errors++; $display("FAIL align_restart_exc got=%b exp=0", id_exc); end
`else
        got_r = {imem_req, imem_addr}; exp_r = {1'b1, 32'h4000};
        checks++; if (got_r !== exp_r) begin errors++; $display("FAIL noalign_req got=%h exp=%h", got_r, exp_r); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        got_h = {id_valid, id_pc, id_instr, id_pc4}; exp_h = {1'b1, 32'h4000, 32'h4000, 32'h4004};
        checks++; if (got_h !== exp_h) begin errors++; $display("FAIL noalign_head got=%h exp=%h", got_h, exp_h); end
`endif
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        imem_ready  = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_reset();
        test_redirect_inflight();
        test_redirect_full();
        test_imem_stall();
        test_wrap();
        test_align();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
